// File: rtl/ebm_pkg.sv
// Shared definitions for the egress-buffer fetch stage.
//   Word flags in bits [DATA_W-1:DATA_W-2]: HEAD=01, MID=11, TAIL=10.
//   Md layout: [7]=outport, [6:0]=buf_id; queued entries prepend the discard flag.
//   MAX_WORDS: a buffer holds at most 16 words.
package ebm_pkg;

   localparam int unsigned MD_W      = 8;
   localparam int unsigned ID_W      = 7;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned ADDR_W    = ID_W + IDX_W;
   localparam int unsigned MAX_WORDS = 16;
   localparam int unsigned QENT_W    = MD_W + 1;

   localparam logic [1:0] FLAG_HEAD = 2'b01;
   localparam logic [1:0] FLAG_MID  = 2'b11;
   localparam logic [1:0] FLAG_TAIL = 2'b10;

   // Queued md entry: discard flag plus the scheduler's md fields
   typedef struct packed {
      logic            discard;
      logic            outport;
      logic [ID_W-1:0] buf_id;
   } md_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_READ,
      ST_RELEASE
   } ebm_state_t;

endpackage

// File: rtl/ebm_md_fifo.sv
// Show-ahead synchronous FIFO holding scheduled mds.
//   clk, rst     : clock, async active-high reset
//   wr, wr_data  : push (accepted when not full, or when a pop happens the same cycle)
//   rd           : pop the head entry (ignored when empty)
//   rd_data_c    : head entry, valid whenever empty_c is low
//   full_c       : DEPTH entries held
//   empty_c      : no entries held
// DEPTH must be a power of two (pointers wrap naturally).
module ebm_md_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data_c,
   output logic             full_c,
   output logic             empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_rd;
   logic             do_wr;

   assign full_c    = (count == CW'(DEPTH));
   assign empty_c   = (count == '0);
   assign do_rd     = rd && !empty_c;
   // A pop in the same cycle frees the slot the push needs
   assign do_wr     = wr && (!full_c || do_rd);
   assign rd_data_c = mem[rd_ptr];

   // Storage array carries no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/ebm_pkt_fetch.sv
// Egress-buffer fetch stage downstream of the egress scheduler.
// Queues each scheduled md, reads the packet words from the shared packet RAM,
// streams them to UDO FIFO 0 or 1, frees the buffer and reports completion.
// Discard-flagged mds are freed without any RAM access.
//   clk, rst                  : clock, async active-high reset
//   in_ebm_md/_wr             : scheduled md {outport, buf_id} and strobe
//   in_ebm_bandwidth_discard  : drop flag sampled with the md strobe
//   out_ebm_ram_rd/_addr      : RAM read, address {buf_id, word_idx}
//   in_ebm_ram_rdata          : RAM data, one cycle after the read
//   pktout_usedw_0/1          : UDO FIFO fill levels (checked at packet start)
//   pktout_data, pktout_wr_0/1: packet words to UDO FIFO 0/1
//   out_ebm_pkt_valid         : pulse per fully transmitted packet
//   out_ebm_free_id/_wr       : buffer id returned to the free list
//   out_ebm_md_ovf            : pulse when an md is lost to a full queue
//   out_ebm_len_err           : pulse when no tail is found within 16 words
// Build option EBM_PKT_CNT_EN adds out_ebm_pktout_cnt and out_ebm_discard_cnt.
module ebm_pkt_fetch
   import ebm_pkg::*;
#(
   parameter int unsigned DATA_W    = 134,
   parameter int unsigned MDQ_DEPTH = 4,
   parameter logic [7:0]  USEDW_TH  = 8'd200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MD_W-1:0]   in_ebm_md,
   input  logic              in_ebm_md_wr,
   input  logic              in_ebm_bandwidth_discard,
   output logic              out_ebm_ram_rd,
   output logic [ADDR_W-1:0] out_ebm_ram_addr,
   input  logic [DATA_W-1:0] in_ebm_ram_rdata,
   input  logic [7:0]        pktout_usedw_0,
   input  logic [7:0]        pktout_usedw_1,
   output logic [DATA_W-1:0] pktout_data,
   output logic              pktout_wr_0,
   output logic              pktout_wr_1,
   output logic              out_ebm_pkt_valid,
   output logic [ID_W-1:0]   out_ebm_free_id,
   output logic              out_ebm_free_wr,
   output logic              out_ebm_md_ovf,
`ifdef EBM_PKT_CNT_EN
   output logic [63:0]       out_ebm_pktout_cnt,
   output logic [63:0]       out_ebm_discard_cnt,
`endif
   output logic              out_ebm_len_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

   ebm_state_t        state;
   logic              cur_port;
   logic [ID_W-1:0]   cur_id;
   logic [IDX_W-1:0]  issue_idx;
   logic              rd_q;
   logic [IDX_W-1:0]  ret_idx;

   logic [QENT_W-1:0] q_wr_data;
   logic [QENT_W-1:0] q_rd_data;
   md_entry_t         q_head;
   logic              q_full;
   logic              q_empty;
   logic              pop_c;

   logic [7:0]        head_usedw_c;
   logic [7:0]        cur_usedw_c;
   logic              ret_tail_c;
   logic              ret_last_c;
   logic              stop_c;
   logic              force_c;

   assign q_wr_data = {in_ebm_bandwidth_discard, in_ebm_md};
   assign q_head    = md_entry_t'(q_rd_data);
   assign pop_c     = (state == ST_IDLE) && !q_empty;

   ebm_md_fifo #(
      .WIDTH (QENT_W),
      .DEPTH (MDQ_DEPTH)
   ) u_md_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr        (in_ebm_md_wr),
      .wr_data   (q_wr_data),
      .rd        (pop_c),
      .rd_data_c (q_rd_data),
      .full_c    (q_full),
      .empty_c   (q_empty)
   );

   // Fill level of the FIFO targeted by the head md / the held md
   assign head_usedw_c = q_head.outport ? pktout_usedw_1 : pktout_usedw_0;
   assign cur_usedw_c  = cur_port       ? pktout_usedw_1 : pktout_usedw_0;

   // Returned-word classification; rd_q marks in_ebm_ram_rdata as valid
   assign ret_tail_c = (in_ebm_ram_rdata[DATA_W-1 -: 2] == FLAG_TAIL);
   assign ret_last_c = (ret_idx == LAST_IDX);
   assign stop_c     = rd_q && (ret_tail_c || ret_last_c);
   assign force_c    = ret_last_c && !ret_tail_c;

   // Fetch FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         cur_port          <= 1'b0;
         cur_id            <= '0;
         issue_idx         <= '0;
         rd_q              <= 1'b0;
         ret_idx           <= '0;
         out_ebm_ram_rd    <= 1'b0;
         out_ebm_ram_addr  <= '0;
         pktout_data       <= '0;
         pktout_wr_0       <= 1'b0;
         pktout_wr_1       <= 1'b0;
         out_ebm_pkt_valid <= 1'b0;
         out_ebm_free_id   <= '0;
         out_ebm_free_wr   <= 1'b0;
         out_ebm_md_ovf    <= 1'b0;
         out_ebm_len_err   <= 1'b0;
      end else begin
         pktout_wr_0       <= 1'b0;
         pktout_wr_1       <= 1'b0;
         out_ebm_pkt_valid <= 1'b0;
         out_ebm_free_wr   <= 1'b0;
         out_ebm_len_err   <= 1'b0;
         rd_q              <= 1'b0;
         out_ebm_md_ovf    <= in_ebm_md_wr && q_full && !pop_c;

         unique case (state)
            ST_IDLE: begin
               if (!q_empty) begin
                  cur_port <= q_head.outport;
                  cur_id   <= q_head.buf_id;
                  if (q_head.discard) begin
                     state           <= ST_RELEASE;
                     out_ebm_free_wr <= 1'b1;
                     out_ebm_free_id <= q_head.buf_id;
                  end else if (head_usedw_c < USEDW_TH) begin
                     state            <= ST_READ;
                     out_ebm_ram_rd   <= 1'b1;
                     out_ebm_ram_addr <= {q_head.buf_id, IDX_W'(0)};
                     issue_idx        <= '0;
                  end else begin
                     state <= ST_HOLD;
                  end
               end
            end

            // Popped md waits here until its FIFO has room to start
            ST_HOLD: begin
               if (cur_usedw_c < USEDW_TH) begin
                  state            <= ST_READ;
                  out_ebm_ram_rd   <= 1'b1;
                  out_ebm_ram_addr <= {cur_id, IDX_W'(0)};
                  issue_idx        <= '0;
               end
            end

            ST_READ: begin
               // Track which word returns next cycle; the read in flight at stop is dropped
               rd_q    <= out_ebm_ram_rd && !stop_c;
               ret_idx <= issue_idx;

               if (rd_q) begin
                  pktout_data     <= force_c ? {FLAG_TAIL, in_ebm_ram_rdata[DATA_W-3:0]}
                                             : in_ebm_ram_rdata;
                  pktout_wr_0     <= !cur_port;
                  pktout_wr_1     <= cur_port;
                  out_ebm_len_err <= force_c;
               end

               if (stop_c) begin
                  state             <= ST_RELEASE;
                  out_ebm_ram_rd    <= 1'b0;
                  out_ebm_free_wr   <= 1'b1;
                  out_ebm_free_id   <= cur_id;
                  out_ebm_pkt_valid <= 1'b1;
               end else if (out_ebm_ram_rd) begin
                  if (issue_idx == LAST_IDX) begin
                     out_ebm_ram_rd <= 1'b0;
                  end else begin
                     issue_idx        <= issue_idx + IDX_W'(1);
                     out_ebm_ram_addr <= {cur_id, issue_idx + IDX_W'(1)};
                  end
               end
            end

            // Free strobe is visible during this cycle
            ST_RELEASE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef EBM_PKT_CNT_EN
   // Statistics: sent packets and freed discards (a free without pkt_valid)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_ebm_pktout_cnt  <= '0;
         out_ebm_discard_cnt <= '0;
      end else begin
         if (out_ebm_pkt_valid) begin
            out_ebm_pktout_cnt <= out_ebm_pktout_cnt + 64'd1;
         end
         if (out_ebm_free_wr && !out_ebm_pkt_valid) begin
            out_ebm_discard_cnt <= out_ebm_discard_cnt + 64'd1;
         end
      end
   end
`endif

endmodule
